// File: rtl/ram_port_arbiter_if.sv
// Two requester ports plus the single shared RAM port served by ram_port_arbiter.
// master = requesters and RAM side, slave = the arbiter.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              REQ0;
  logic              WE0;
  logic [ADDR_W-1:0] ADDR0;
  logic [DATA_W-1:0] DI0;
  logic              GNT0;
  logic              VLD0;
  logic [DATA_W-1:0] DO0;

  logic              REQ1;
  logic              WE1;
  logic [ADDR_W-1:0] ADDR1;
  logic [DATA_W-1:0] DI1;
  logic              GNT1;
  logic              VLD1;
  logic [DATA_W-1:0] DO1;

  logic              RAM_EN;
  logic              RAM_WE;
  logic [ADDR_W-1:0] RAM_ADDR;
  logic [DATA_W-1:0] RAM_DI;
  logic              RAM_RST;
  logic [DATA_W-1:0] RAM_DO;

  modport master (
    output REQ0, WE0, ADDR0, DI0, REQ1, WE1, ADDR1, DI1, RAM_DO,
    input  GNT0, VLD0, DO0, GNT1, VLD1, DO1,
    input  RAM_EN, RAM_WE, RAM_ADDR, RAM_DI, RAM_RST
  );

  modport slave (
    input  REQ0, WE0, ADDR0, DI0, REQ1, WE1, ADDR1, DI1, RAM_DO,
    output GNT0, VLD0, DO0, GNT1, VLD1, DO1,
    output RAM_EN, RAM_WE, RAM_ADDR, RAM_DI, RAM_RST
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for one synchronous single-port RAM with read-data steering.
// Define RAM_PORT_ARBITER_ROUND_ROBIN_EN for round-robin with burst limit; default is fixed priority to requester 0.
module ram_port_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic              CLK,
  input  logic              RST,
  ram_port_arbiter_if.slave bus
);
  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

  logic              gnt0;
  logic              gnt1;
  logic              any_gnt;
  logic              contended;
  logic              winner;
  logic              burst_hit;
  logic              ptr;
  logic [3:0]        burst_cnt;
  logic              last_gnt;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_di;
  logic              owner_vld_q;
  logic              owner_vld_d;
  logic              owner_id_q;
  logic              owner_id_d;

`ifdef RAM_PORT_ARBITER_ROUND_ROBIN_EN
  logic       ptr_q;
  logic       ptr_d;
  logic [3:0] burst_q;
  logic [3:0] burst_d;
  logic       last_q;
  logic       last_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q   <= 1'b0;
      burst_q <= 4'd0;
      last_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
      last_q  <= last_d;
    end
  end

  // burst_q counts the current run of grants to last_q; 0 means the run was broken by an idle cycle
  always_comb begin
    ptr_d   = ptr_q;
    burst_d = burst_q;
    last_d  = last_q;
    if (any_gnt) begin
      last_d = gnt1;
      if (burst_q != 4'd0 && last_q == gnt1) begin
        burst_d = (burst_q == BURST_LIMIT) ? burst_q : burst_q + 4'd1;
      end else begin
        burst_d = 4'd1;
      end
      if (contended) begin
        ptr_d = ~gnt1;
      end
    end else begin
      burst_d = 4'd0;
    end
  end

  assign ptr       = ptr_q;
  assign burst_cnt = burst_q;
  assign last_gnt  = last_q;
`else
  assign ptr       = 1'b0;
  assign burst_cnt = 4'd0;
  assign last_gnt  = 1'b0;
`endif

  always_comb begin
    contended = bus.REQ0 & bus.REQ1;
    burst_hit = (burst_cnt == BURST_LIMIT) && (last_gnt == ptr);
    winner    = burst_hit ? ~ptr : ptr;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    if (!RST) begin
      if (contended) begin
        gnt0 = ~winner;
        gnt1 = winner;
      end else begin
        gnt0 = bus.REQ0;
        gnt1 = bus.REQ1;
      end
    end
    any_gnt = gnt0 | gnt1;
  end

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_di   = '0;
    if (gnt0) begin
      ram_we   = bus.WE0;
      ram_addr = bus.ADDR0;
      ram_di   = bus.DI0;
    end else if (gnt1) begin
      ram_we   = bus.WE1;
      ram_addr = bus.ADDR1;
      ram_di   = bus.DI1;
    end
    owner_vld_d = any_gnt & ~ram_we;
    owner_id_d  = gnt1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      owner_vld_q <= 1'b0;
      owner_id_q  <= 1'b0;
    end else begin
      owner_vld_q <= owner_vld_d;
      owner_id_q  <= owner_id_d;
    end
  end

  assign bus.GNT0     = gnt0;
  assign bus.GNT1     = gnt1;
  assign bus.RAM_EN   = any_gnt;
  assign bus.RAM_WE   = ram_we;
  assign bus.RAM_ADDR = ram_addr;
  assign bus.RAM_DI   = ram_di;
  assign bus.RAM_RST  = 1'b0;
  // a read launched just before reset must not surface while reset is held
  assign bus.VLD0     = owner_vld_q & ~owner_id_q & ~RST;
  assign bus.VLD1     = owner_vld_q & owner_id_q & ~RST;
  assign bus.DO0      = bus.RAM_DO;
  assign bus.DO1      = bus.RAM_DO;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized bench for ram_port_arbiter: behavioural grant/RAM model checked every cycle, plus literal anchors.
module tb_ram_port_arbiter;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 16;
  localparam int MAX_BURST = 4;
  localparam int DEPTH     = 1 << ADDR_W;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // RAM emulation driven by the DUT's RAM port
  logic              clear_mem = 1'b1;
  logic [DATA_W-1:0] ram_mem [DEPTH];
  logic [DATA_W-1:0] ram_do_r;
  always @(posedge CLK) begin
    if (clear_mem) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= '0;
    end else if (bus.RAM_EN) begin
      if (bus.RAM_WE) ram_mem[bus.RAM_ADDR] <= bus.RAM_DI;
      else            ram_do_r <= ram_mem[bus.RAM_ADDR];
    end
  end
  assign bus.RAM_DO = ram_do_r;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  // requester intent
  logic              r_req  [2];
  logic              r_we   [2];
  logic [ADDR_W-1:0] r_addr [2];
  logic [DATA_W-1:0] r_di   [2];

  // reference model
  logic [DATA_W-1:0] m_mem [DEPTH];
  int                m_ptr;
  int                m_run_who;
  int                m_run_len;
  logic              m_pend_valid;
  int                m_pend_who;
  logic [DATA_W-1:0] m_pend_data;
  int                last_win;

  logic              obs_gnt0, obs_gnt1, obs_vld0, obs_vld1;
  logic [DATA_W-1:0] obs_do0, obs_do1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL cyc=%0d %s: got %h expected %h", cyc, name, act, exp);
    end
  endtask

  task automatic apply();
    bus.REQ0 = r_req[0]; bus.WE0 = r_we[0]; bus.ADDR0 = r_addr[0]; bus.DI0 = r_di[0];
    bus.REQ1 = r_req[1]; bus.WE1 = r_we[1]; bus.ADDR1 = r_addr[1]; bus.DI1 = r_di[1];
  endtask

  task automatic set_req(input int n, input logic req, input logic we,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    r_req[n] = req; r_we[n] = we; r_addr[n] = a; r_di[n] = d;
    apply();
  endtask

  // One clock: compare at negedge against the model, then advance the model after the edge
  task automatic step();
    int                w;
    logic              rst_s;
    logic              e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_di;
    logic              e_vld0, e_vld1;
    @(negedge CLK);
    rst_s = RST;
    w = -1;
    if (!rst_s) begin
      if (r_req[0] && !r_req[1]) w = 0;
      else if (!r_req[0] && r_req[1]) w = 1;
      else if (r_req[0] && r_req[1]) begin
`ifdef RAM_PORT_ARBITER_ROUND_ROBIN_EN
        w = m_ptr;
        if (m_run_len >= MAX_BURST && m_run_who == w) w = 1 - w;
`else
        w = 0;
`endif
      end
    end
    e_we = 1'b0; e_addr = '0; e_di = '0;
    if (w >= 0) begin e_we = r_we[w]; e_addr = r_addr[w]; e_di = r_di[w]; end
    e_vld0 = !rst_s && m_pend_valid && m_pend_who == 0;
    e_vld1 = !rst_s && m_pend_valid && m_pend_who == 1;
    chk("GNT0", 32'(bus.GNT0), 32'(w == 0));
    chk("GNT1", 32'(bus.GNT1), 32'(w == 1));
    chk("RAM_EN", 32'(bus.RAM_EN), 32'(w >= 0));
    chk("RAM_WE", 32'(bus.RAM_WE), 32'(e_we));
    chk("RAM_ADDR", 32'(bus.RAM_ADDR), 32'(e_addr));
    chk("RAM_DI", 32'(bus.RAM_DI), 32'(e_di));
    chk("RAM_RST", 32'(bus.RAM_RST), 32'd0);
    chk("VLD0", 32'(bus.VLD0), 32'(e_vld0));
    chk("VLD1", 32'(bus.VLD1), 32'(e_vld1));
    if (e_vld0) chk("DO0", 32'(bus.DO0), 32'(m_pend_data));
    if (e_vld1) chk("DO1", 32'(bus.DO1), 32'(m_pend_data));
    obs_gnt0 = bus.GNT0; obs_gnt1 = bus.GNT1;
    obs_vld0 = bus.VLD0; obs_vld1 = bus.VLD1;
    obs_do0  = bus.DO0;  obs_do1  = bus.DO1;
    $display("[TB] cyc=%0d rst=%0d req=%0d%0d win=%0d vld=%0d%0d", cyc, rst_s,
             r_req[0], r_req[1], w, bus.VLD0, bus.VLD1);
    @(posedge CLK);
    #1;
    cyc++;
    last_win = w;
    if (rst_s) begin
      m_ptr = 0; m_run_len = 0; m_run_who = 0; m_pend_valid = 1'b0;
    end else begin
      m_pend_valid = (w >= 0) && !e_we;
      m_pend_who   = w;
      if (m_pend_valid) m_pend_data = m_mem[e_addr];
      if (w >= 0 && e_we) m_mem[e_addr] = e_di;
      if (w < 0) m_run_len = 0;
      else if (m_run_len > 0 && m_run_who == w) m_run_len++;
      else begin m_run_who = w; m_run_len = 1; end
      if (r_req[0] && r_req[1]) m_ptr = 1 - w;
    end
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < n; i++) step();
    RST = 1'b0;
  endtask

  int run1, max_run1;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_ptr = 0; m_run_len = 0; m_run_who = 0; m_pend_valid = 1'b0;
    m_pend_who = 0; m_pend_data = '0; last_win = -1;
    do_reset(3);
    clear_mem = 1'b0;

    // write then read same address
    set_req(0, 1'b1, 1'b1, 8'h05, 16'hA5A5); step();
    chk("wr_gnt0", 32'(obs_gnt0), 32'd1);
    set_req(0, 1'b1, 1'b0, 8'h05, 16'h0000); step();
    chk("rd_gnt0", 32'(obs_gnt0), 32'd1);
    set_req(0, 1'b0, 1'b0, '0, '0); step();
    chk("rd_vld0", 32'(obs_vld0), 32'd1);
    chk("rd_do0", 32'(obs_do0), 32'hA5A5);
    chk("rd_vld1", 32'(obs_vld1), 32'd0);

    // both requesting for 6 cycles
    do_reset(1);
    set_req(0, 1'b1, 1'b0, 8'h01, '0);
    set_req(1, 1'b1, 1'b0, 8'h02, '0);
    for (int i = 0; i < 6; i++) begin
      step();
`ifdef RAM_PORT_ARBITER_ROUND_ROBIN_EN
      chk("alt_gnt0", 32'(obs_gnt0), 32'((i % 2) == 0));
`else
      chk("fix_gnt0", 32'(obs_gnt0), 32'd1);
`endif
    end
    set_req(0, 1'b0, 1'b0, '0, '0); step();
    chk("drop_gnt1", 32'(obs_gnt1), 32'd1);

`ifdef RAM_PORT_ARBITER_ROUND_ROBIN_EN
    // pointer at 1, requester 1 collects MAX_BURST grants, then loses the contended cycle
    do_reset(1);
    set_req(0, 1'b1, 1'b0, 8'h03, '0);
    set_req(1, 1'b1, 1'b0, 8'h04, '0); step();
    chk("pre_gnt0", 32'(obs_gnt0), 32'd1);
    set_req(0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < MAX_BURST; i++) step();
    set_req(0, 1'b1, 1'b0, 8'h03, '0); step();
    chk("burst_gnt0", 32'(obs_gnt0), 32'd1);
`endif

    // requester 1 held with 8 reads, requester 0 joins at cycle 2
    do_reset(1);
    set_req(1, 1'b1, 1'b0, 8'h07, '0);
    run1 = 0; max_run1 = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) set_req(0, 1'b1, 1'b0, 8'h08, '0);
      step();
      if (i == 2) chk("join_gnt0", 32'(obs_gnt0), 32'd1);
      run1 = obs_gnt1 ? run1 + 1 : 0;
      if (run1 > max_run1) max_run1 = run1;
    end
    chk("max_run1_le_burst", 32'(max_run1 <= MAX_BURST), 32'd1);

    // read, then reset on the following cycle
    do_reset(1);
    set_req(0, 1'b1, 1'b0, 8'h05, '0); step();
    RST = 1'b1; step();
    chk("rst_vld0", 32'(obs_vld0), 32'd0);
    chk("rst_vld1", 32'(obs_vld1), 32'd0);
    chk("rst_gnt0", 32'(obs_gnt0), 32'd0);
    chk("rst_gnt1", 32'(obs_gnt1), 32'd0);
    RST = 1'b0;

    // alternating reads with no bubble
    set_req(0, 1'b1, 1'b1, 8'h10, 16'h1111); set_req(1, 1'b0, 1'b0, '0, '0); step();
    set_req(0, 1'b0, 1'b0, '0, '0); set_req(1, 1'b1, 1'b1, 8'hFF, 16'h2222); step();
    set_req(0, 1'b1, 1'b0, 8'h10, '0); set_req(1, 1'b0, 1'b0, '0, '0); step();
    set_req(0, 1'b0, 1'b0, '0, '0); set_req(1, 1'b1, 1'b0, 8'hFF, '0); step();
    chk("alt_vld0", 32'(obs_vld0), 32'd1);
    chk("alt_do0", 32'(obs_do0), 32'h1111);
    set_req(1, 1'b0, 1'b0, '0, '0); step();
    chk("alt_vld1", 32'(obs_vld1), 32'd1);
    chk("alt_do1", 32'(obs_do1), 32'h2222);

    // random traffic with hold-until-granted requesters and occasional reset
    last_win = -1;
    for (int c = 0; c < 3000; c++) begin
      RST = ($urandom_range(0, 99) < 2);
      for (int n = 0; n < 2; n++) begin
        if (!r_req[n] || last_win == n) begin
          if ($urandom_range(0, 99) < 65) begin
            r_req[n]  = 1'b1;
            r_we[n]   = 1'($urandom_range(0, 1));
            r_addr[n] = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
            r_di[n]   = 16'($urandom);
          end else begin
            r_req[n] = 1'b0;
          end
        end
      end
      apply();
      step();
    end
    RST = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the RAM word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning the RAM data width.
REQ-003 The block SHALL have parameter MAX_BURST, default 4, meaning the maximum number of consecutive grants to one requester while the other requester is waiting; legal range 1..15.
REQ-004 The block SHALL have port CLK, input, width 1: the single clock, rising-edge active.
REQ-005 The block SHALL have port RST, input, width 1: reset, synchronous and active-high.
REQ-006 The block SHALL have, for n in {0,1}, port REQn, input, width 1: requester n presents an access this cycle.
REQ-007 The block SHALL have, for n in {0,1}, port WEn, input, width 1: 1 = write, 0 = read.
REQ-008 The block SHALL have, for n in {0,1}, port ADDRn, input, width ADDR_W: the access word address.
REQ-009 The block SHALL have, for n in {0,1}, port DIn, input, width DATA_W: the write data.
REQ-010 The block SHALL have, for n in {0,1}, port GNTn, output, width 1: the access from requester n is accepted this cycle.
REQ-011 The block SHALL have, for n in {0,1}, port VLDn, output, width 1: read data for requester n is on DOn this cycle.
REQ-012 The block SHALL have, for n in {0,1}, port DOn, output, width DATA_W: read data.
REQ-013 The block SHALL have port RAM_EN, output, width 1: RAM port enable.
REQ-014 The block SHALL have port RAM_WE, output, width 1: RAM port write enable.
REQ-015 The block SHALL have port RAM_ADDR, output, width ADDR_W: RAM port address.
REQ-016 The block SHALL have port RAM_DI, output, width DATA_W: RAM port write data.
REQ-017 The block SHALL have port RAM_RST, output, width 1: RAM port output reset; it SHALL be tied to 0.
REQ-018 The block SHALL have port RAM_DO, input, width DATA_W: RAM port read data, registered in the RAM, valid one cycle after the read.

Function
REQ-019 Grant SHALL be combinational from REQ0, REQ1, the priority pointer and the burst counter; at most one GNTn SHALL be high per cycle, and GNTn SHALL only be high while REQn is high.
REQ-020 RAM_EN SHALL equal GNT0|GNT1.
- RAM_WE, RAM_ADDR and RAM_DI SHALL be muxed from the granted requester.
- When no requester is granted, RAM_WE SHALL be 0 and RAM_ADDR and RAM_DI SHALL be 0.
REQ-021 Handshake: a requester SHALL hold REQn, WEn, ADDRn and DIn stable until it samples GNTn=1 at a rising edge; each GNT cycle transfers exactly one access.
REQ-022 Read latency: a granted read (WEn=0) at cycle t SHALL produce VLDn=1 at cycle t+1 with DOn=RAM_DO; a registered owner tag SHALL steer VLD.
- A granted write SHALL produce no VLD pulse.
REQ-023 DO0 and DO1 SHALL both be driven from RAM_DO at all times; DOn SHALL only be meaningful while VLDn=1.
REQ-024 Single request: when exactly one REQn is high, that requester SHALL be granted, regardless of the pointer or the burst counter.
REQ-025 Contention: when both requests are high, the requester indicated by the pointer SHALL win unless it has already received MAX_BURST consecutive grants; in that case the other requester SHALL win.
REQ-026 A 4-bit burst counter SHALL:
- increment on each consecutive grant to the same requester;
- load 1 on a grant to a different requester;
- load 0 in any cycle with no grant;
- saturate at MAX_BURST.
REQ-027 Back-to-back grants to alternating requesters SHALL be supported at one access per cycle, with no bubble.
REQ-028 Same-address write/read in consecutive cycles SHALL return the newly written data; this follows from the RAM's ordering and needs no extra logic.

Reset
REQ-029 While RST=1 at a rising edge, the block SHALL clear the following, and SHALL force GNT0, GNT1, RAM_EN and RAM_WE to 0 combinationally while RST=1:
- pointer to requester 0;
- burst counter to 0;
- owner tag to none;
- VLD0 and VLD1 to 0.
REQ-030 A read granted in the cycle before RST asserts SHALL NOT produce a VLD pulse.

Configuration
REQ-031 When macro RAM_PORT_ARBITER_ROUND_ROBIN_EN is defined, the pointer SHALL move to the non-granted requester after every contended grant (round-robin), and the burst limit SHALL apply.
REQ-032 When RAM_PORT_ARBITER_ROUND_ROBIN_EN is undefined, requester 0 SHALL always have fixed priority, the burst counter SHALL be absent, and requester 1 SHALL be granted only when REQ0=0.

Verification
REQ-033 Reset, then REQ0 write ADDR0=8'h05, DI0=16'hA5A5, then REQ0 read 8'h05 -> GNT0 in both cycles, VLD0=1 one cycle after the read, DO0=16'hA5A5, VLD1=0.
REQ-034 REQ0 and REQ1 both high for 6 cycles (ROUND_ROBIN_EN defined) -> grants alternate 0,1,0,1,0,1.
REQ-035 MAX_BURST=4, REQ1 held with 8 reads, REQ0 asserted at cycle 2 and held -> REQ1 is granted at most 4 consecutive cycles, then GNT0=1.
REQ-036 ROUND_ROBIN_EN undefined, both REQ held -> GNT0 every cycle, GNT1 only after REQ0 drops.
REQ-037 Read granted at cycle t, RST=1 at cycle t+1 -> VLD0=VLD1=0 and GNT0=GNT1=0 during reset.
REQ-038 Alternating read REQ0 addr 8'h10 and REQ1 addr 8'hFF on consecutive cycles -> VLD0 and VLD1 on consecutive cycles, each with its own data and no bubble.
